// File: rtl/config_pkg.sv
// Shared constants, state encoding and header validation for the ALU frame parser.
package config_pkg;

  localparam logic [7:0]  OP_ECHO = 8'hEC;
  localparam logic [7:0]  OP_ADD  = 8'hAD;
  localparam logic [7:0]  OP_MUL  = 8'hAF;
  localparam logic [7:0]  OP_DIV  = 8'hF6;
  localparam logic [15:0] HDR_LEN = 16'd4;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_ECHO,
    ST_OPERAND,
    ST_DRAIN
  } state_t;

  // Opcode-specific length rules; unknown opcodes never pass.
  function automatic logic frame_len_ok(input logic [7:0] op, input logic [15:0] len);
    case (op)
      OP_ECHO:        return len >= 16'd5;
      OP_ADD, OP_MUL: return (len >= 16'd12) && (len[1:0] == 2'b00);
      OP_DIV:         return len == 16'd12;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_packer.sv
// Packs a little-endian byte stream into 32-bit words with a last flag.
module alu_operand_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [31:0] out_word_o,
  output logic        out_last_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;

  // A full word blocks further bytes until it is taken; a byte may enter on the take cycle.
  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_word_o  = word_q;
  assign out_last_o  = last_q;
  assign out_valid_o = valid_q;

  // Shift bytes in from the top so byte 0 ends up in [7:0] after four bytes.
  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (in_valid_i && in_ready_o) begin
      word_d = {in_data_i, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        valid_d = 1'b1;
        last_d  = in_last_i;
      end
    end
  end

  // Packer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/alu_frame_parser.sv
// Parses UART frames (opcode, reserved, 16-bit length, payload) into echo bytes or ALU operands.
module alu_frame_parser
  import config_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic [7:0]  opcode_o,
  output logic [31:0] operand_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        operand_last_o,
  output logic        frame_err_o
);

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic        rsvd_ok_q, rsvd_ok_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] remain_q, remain_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        err_q, err_d;
  logic [7:0]  echo_data_q, echo_data_d;
  logic        echo_valid_q, echo_valid_d;

  logic        rx_ready, rx_fire;
  logic [15:0] len_w;
  logic        hdr_ok;
  logic        pk_in_valid, pk_in_ready, pk_in_last;
  logic        pk_out_valid, pk_out_last;
  logic [31:0] pk_word;

  assign rx_fire     = rx_valid_i && rx_ready;
  assign len_w       = {rx_data_i, len_lo_q};
  assign hdr_ok      = frame_len_ok(op_q, len_w) && rsvd_ok_q && ({1'b0, len_w} <= MAX_LEN_W);
  assign pk_in_valid = rx_fire && (state_q == ST_OPERAND);
  assign pk_in_last  = (remain_q == 16'd1);

  alu_operand_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (rx_data_i),
    .in_valid_i  (pk_in_valid),
    .in_last_i   (pk_in_last),
    .in_ready_o  (pk_in_ready),
    .out_word_o  (pk_word),
    .out_last_o  (pk_out_last),
    .out_valid_o (pk_out_valid),
    .out_ready_i (operand_ready_i)
  );

  // Byte acceptance: header always open, payload paced by the downstream channel.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI: rx_ready = 1'b1;
      ST_ECHO:    rx_ready = (remain_q != '0) && (!echo_valid_q || echo_ready_i);
      ST_OPERAND: rx_ready = (remain_q != '0) && pk_in_ready;
      ST_DRAIN:   rx_ready = (remain_q != '0);
      default:    rx_ready = 1'b0;
    endcase
    if (rst_i) rx_ready = 1'b0;
  end

  // Next-state and datapath updates for the frame FSM.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rsvd_ok_d    = rsvd_ok_q;
    len_lo_d     = len_lo_q;
    remain_d     = remain_q;
    opcode_d     = opcode_q;
    err_d        = 1'b0;
    echo_data_d  = echo_data_q;
    echo_valid_d = echo_valid_q;
    if (echo_valid_q && echo_ready_i) echo_valid_d = 1'b0;
    case (state_q)
      ST_OPCODE: if (rx_fire) begin
        op_d    = rx_data_i;
        state_d = ST_RSVD;
      end
      ST_RSVD: if (rx_fire) begin
        rsvd_ok_d = (rx_data_i == 8'h00);
        state_d   = ST_LEN_LO;
      end
      ST_LEN_LO: if (rx_fire) begin
        len_lo_d = rx_data_i;
        state_d  = ST_LEN_HI;
      end
      ST_LEN_HI: if (rx_fire) begin
        opcode_d = op_q;
        remain_d = len_w - HDR_LEN;
        if (hdr_ok) begin
          state_d = (op_q == OP_ECHO) ? ST_ECHO : ST_OPERAND;
        end else begin
          err_d = 1'b1;
          if (len_w <= HDR_LEN) begin
            remain_d = '0;
            state_d  = ST_OPCODE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_ECHO: begin
        if (rx_fire) begin
          echo_data_d  = rx_data_i;
          echo_valid_d = 1'b1;
          remain_d     = remain_q - 16'd1;
        end else if ((remain_q == '0) && (!echo_valid_q || echo_ready_i)) begin
          state_d = ST_OPCODE;
        end
      end
      ST_OPERAND: begin
        if (rx_fire) begin
          remain_d = remain_q - 16'd1;
        end else if ((remain_q == '0) && (!pk_out_valid || operand_ready_i)) begin
          state_d = ST_OPCODE;
        end
      end
      ST_DRAIN: if (rx_fire) begin
        remain_d = remain_q - 16'd1;
        if (remain_q == 16'd1) state_d = ST_OPCODE;
      end
      default: state_d = ST_OPCODE;
    endcase
  end

  // Frame FSM and output registers; reset abandons any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_OPCODE;
      op_q         <= '0;
      rsvd_ok_q    <= 1'b0;
      len_lo_q     <= '0;
      remain_q     <= '0;
      opcode_q     <= '0;
      err_q        <= 1'b0;
      echo_data_q  <= '0;
      echo_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rsvd_ok_q    <= rsvd_ok_d;
      len_lo_q     <= len_lo_d;
      remain_q     <= remain_d;
      opcode_q     <= opcode_d;
      err_q        <= err_d;
      echo_data_q  <= echo_data_d;
      echo_valid_q <= echo_valid_d;
    end
  end

  assign rx_ready_o      = rx_ready;
  assign echo_data_o     = echo_data_q;
  assign echo_valid_o    = echo_valid_q;
  assign opcode_o        = opcode_q;
  assign operand_o       = pk_word;
  assign operand_valid_o = pk_out_valid;
  assign operand_last_o  = pk_out_last;
  assign frame_err_o     = err_q;

endmodule

// File: doc/alu_frame_parser.md
ALU_FRAME_PARSER -- requirements
Module: alu_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16'hFFFF, meaning largest accepted total frame length in bytes.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_data_i  input  8  received UART byte.
REQ-005 SHALL have port rx_valid_i  input  1  rx_data_i valid.
REQ-006 SHALL have port rx_ready_o  output  1  parser accepts byte this cycle.
REQ-007 SHALL have port echo_data_o  output  8  echo byte to TX arbiter.
REQ-008 SHALL have port echo_valid_o / echo_ready_i  output/input  1/1  echo handshake.
REQ-009 SHALL have port opcode_o  output  8  opcode of current frame, stable while operand_valid_o high.
REQ-010 SHALL have port operand_o  output  32  assembled operand, little-endian byte order.
REQ-011 SHALL have port operand_valid_o / operand_ready_i  output/input  1/1  operand handshake.
REQ-012 SHALL have port operand_last_o  output  1  marks final operand of frame, valid with operand_valid_o.
REQ-013 SHALL have port frame_err_o  output  1  one-cycle pulse on rejected frame.

Function
REQ-014 SHALL transfer a byte only when rx_valid_i and rx_ready_o are both high; same rule for echo and operand channels.
REQ-015 SHALL parse frame = opcode, reserved byte, LEN[7:0], LEN[15:8], payload of LEN-4 bytes; LEN counts header.
REQ-016 SHALL implement states OPCODE -> RSVD -> LEN_LO -> LEN_HI -> {ECHO | OPERAND | DRAIN} -> OPCODE.
REQ-017 SHALL validate at LEN_HI acceptance: 0xEC needs LEN>=5; 0xAD/0xAF need LEN>=12 and (LEN-4)%4==0; 0xF6 needs LEN==12; all need LEN<=MAX_LEN and reserved byte 0x00.
REQ-018 SHALL, on failed validation or unknown opcode, pulse frame_err_o the cycle after LEN_HI acceptance and enter DRAIN; if LEN<=4 go directly to OPCODE.
REQ-019 SHALL in DRAIN accept and discard bytes (rx_ready_o=1) until LEN-4 payload bytes consumed.
REQ-020 SHALL in ECHO register each accepted byte onto echo_data_o with echo_valid_o high the next cycle (latency 1); rx_ready_o = !echo_valid_o || echo_ready_i.
REQ-021 SHALL in OPERAND shift bytes into a 32-bit register, byte 0 into [7:0]; after 4th byte assert operand_valid_o next cycle.
REQ-022 SHALL hold rx_ready_o low in OPERAND while operand_valid_o high and operand_ready_i low; accept a new byte in the same cycle the operand handshake completes.
REQ-023 SHALL assert operand_last_o when the operand holds the frame's final payload bytes.
REQ-024 SHALL track remaining payload in a 16-bit down-counter; return to OPCODE when it reaches 0 and any pending output handshake completes.
REQ-025 SHALL keep opcode_o equal to the current frame opcode from LEN_HI acceptance until the last operand is consumed.
REQ-026 SHALL hold rx_ready_o high in OPCODE, RSVD, LEN_LO, LEN_HI.

Reset
REQ-027 SHALL on rst_i high at a clock edge enter OPCODE, clear counters, drive rx_ready_o=0 during reset, echo_valid_o=0, operand_valid_o=0, operand_last_o=0, frame_err_o=0, operand_o=0, echo_data_o=0, opcode_o=0.
REQ-028 SHALL abandon any partial frame on reset mid-operation; no output from that frame after reset.

Structure
REQ-029 SHALL take opcode constants (OP_ECHO=0xEC, OP_ADD=0xAD, OP_MUL=0xAF, OP_DIV=0xF6), header length 4 and state enum from config_pkg.
REQ-030 SHALL place byte-to-word packing in sub-module alu_operand_packer (byte in, 32-bit word out with last flag, ready/valid both sides).

Verification
REQ-031 Echo: EC 00 07 00 11 22 33 -> echo bytes 11,22,33 in order, no operand, no error.
REQ-032 Add: AD 00 0C 00 01 00 00 00 FF FF FF FF -> operands 0x00000001 (last=0), 0xFFFFFFFF (last=1), opcode_o=AD.
REQ-033 Backpressure: same add frame with operand_ready_i low for 20 cycles -> rx_ready_o low, operand_o stable, no byte lost.
REQ-034 Bad length: F6 00 10 00 + 12 bytes -> frame_err_o single pulse, 12 bytes drained, following EC 00 05 00 AA echoes AA.
REQ-035 Unknown opcode: 42 00 06 00 x y -> error pulse, 2 bytes drained, parser back in OPCODE.
REQ-036 Reset after 6 payload bytes of a 3-operand AF frame -> no operands emitted, next valid frame parsed correctly.
